// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch
//                sequencer (state encoding, instruction size, memory size).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Bytes per instruction word; the PC advances by this amount
  localparam int INST_BYTES = 4;

  // Default instruction memory size in bytes
  localparam int MEM_BYTES_DEFAULT = 80;

  // Sequencer control states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  // A target is usable only when it lands on a word boundary
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Two-entry first-word-fall-through FIFO with synchronous
//                flush. entry0 is always the head; entry1 the second slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [1:0]       count;
  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a full FIFO may accept a push
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign head_data = entry0;
  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);

  // Storage and occupancy; flush discards everything and wins over push/pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          entry1 <= '0;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Walks the PC through a combinational instruction memory,
//                buffers {pc, inst} pairs in a 2-entry FIFO and streams them
//                to decode over valid/ready. Supports redirects with flush
//                and a sticky fault on misaligned targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  // Highest PC that still addresses a whole instruction inside memory
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INST_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_BYTES);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;

  logic              push;
  logic              pop;
  logic              flush;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W+31:0] push_data;
  logic [ADDR_W+31:0] head_data;

  logic              redirect_taken;
  logic              pc_in_range;

  assign inst_addr   = pc;
  assign pc_in_range = (pc <= LAST_PC);
  assign push_data   = {pc, inst_data};

  // Redirects are only meaningful once fetching has begun and before a fault
  assign redirect_taken = redirect_valid &&
                          ((state == ST_RUN) || (state == ST_DRAIN) || (state == ST_DONE));

  // Decode consumes the head whenever it is offered and accepted
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Head entry is masked when empty so stale data never leaks onto the bus
  assign out_inst = out_valid ? head_data[31:0]        : 32'h0;
  assign out_pc   = out_valid ? head_data[ADDR_W+31:32] : '0;

  fetch_fifo #(
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Next-state, next-PC and FIFO control; a redirect overrides any push
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;

    if (redirect_taken) begin
      flush = 1'b1;
      if (!is_word_aligned(redirect_pc[1:0])) begin
        state_nxt = ST_FAULT;
      end else begin
        pc_nxt    = redirect_pc;
        state_nxt = (redirect_pc <= LAST_PC) ? ST_RUN : ST_DRAIN;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_RUN;
            pc_nxt    = '0;
          end
        end
        ST_RUN: begin
          if (!pc_in_range) begin
            state_nxt = ST_DRAIN;
          end else if (!fifo_full || pop) begin
            push   = 1'b1;
            pc_nxt = pc + PC_STEP;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // State, PC and status flags, all registered from the next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done  <= (state_nxt == ST_DONE);
      fault <= (state_nxt == ST_FAULT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Scoreboard bench for fetch_sequencer. A stream model turns
//                start/redirect into the list of {pc, inst} pairs decode
//                should see; a monitor pops and compares on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int MEM_BYTES = 80;
  localparam int ADDR_W    = 64;
  localparam int NWORDS    = MEM_BYTES / 4;
  localparam int LAST      = MEM_BYTES - 4;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FAULT  = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;
  logic              done;
  logic              fault;

  logic [31:0] mem [NWORDS];
  item_t       exp_q[$];
  int          mstate     = M_IDLE;
  int          quiet_req  = 0;
  int          quiet_seen = 0;
  int          checks     = 0;
  int          fails      = 0;

  fetch_sequencer #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .busy           (busy),
    .done           (done),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory
  always_comb begin
    inst_data = 32'h0;
    if (inst_addr < 64'(MEM_BYTES)) inst_data = mem[inst_addr[6:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every word from 'from' to the end of memory, in program order
  task automatic load_stream(input logic [63:0] from);
    for (longint unsigned a = from; a <= longint'(LAST); a += 4) begin
      int idx;
      item_t it;
      idx     = int'(a >> 2);
      it.pc   = a;
      it.inst = mem[idx];
      exp_q.push_back(it);
    end
  endtask

  // Stream model: start begins the whole program, a redirect abandons what
  // decode has not yet taken and restarts the program from the target
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      mstate = M_IDLE;
    end else if (mstate == M_IDLE) begin
      if (start) begin
        mstate = M_ACTIVE;
        load_stream(64'h0);
      end
    end else if (mstate == M_ACTIVE && redirect_valid) begin
      exp_q.delete();
      quiet_req++;
      if (redirect_pc[1:0] != 2'b00) mstate = M_FAULT;
      else                           load_stream(redirect_pc);
    end
  end

  // Monitor: compare each accepted output against the head of the model
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (quiet_seen != quiet_req) begin
        chk("valid_after_redirect", {63'b0, out_valid}, 64'h0);
        quiet_seen = quiet_req;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got pc 0x%0h, expected no output (t=%0t)", out_pc, $time);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h00800513;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'h0);
    chk({tag, "_flags"}, {61'b0, busy, done, fault}, 64'h0);
    chk({tag, "_pc"}, out_pc, 64'h0);
    chk({tag, "_inst"}, {32'h0, out_inst}, 64'h0);
    chk({tag, "_addr"}, inst_addr, 64'h0);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    tick(2);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Wait (bounded) for done, then confirm the model stream was fully consumed
  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", {63'b0, (n < limit)}, 64'h1);
    chk("stream_consumed", 64'(exp_q.size()), 64'h0);
    tick(1);
    chk("done_not_busy", {62'b0, done, busy}, 64'h2);
  endtask

  initial begin
    fill_mem();

    // Full program with out_ready held high: latency and throughput
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("latency_n1_valid", {63'b0, out_valid}, 64'h0);
    @(negedge clk);
    chk("latency_n2_valid", {63'b0, out_valid}, 64'h1);
    chk("first_pc", out_pc, 64'h0);
    chk("first_inst", {32'h0, out_inst}, 64'h00800513);
    for (int i = 1; i < NWORDS; i++) begin
      @(negedge clk);
      chk("throughput_pc", out_pc, 64'(i * 4));
    end
    tick(1);
    wait_done(20);

    // Back-pressure: FIFO fills with 0 and 4, PC stalls at 8
    do_reset();
    pulse_start();
    tick(5);
    chk("stall_addr", inst_addr, 64'h8);
    chk("stall_head", out_pc, 64'h0);
    chk("stall_valid", {63'b0, out_valid}, 64'h1);
    out_ready = 1'b1;
    wait_done(40);

    // Redirect while full: head is consumed, remainder flushed
    do_reset();
    pulse_start();
    tick(5);
    out_ready = 1'b1;
    do_redirect(64'h40);
    @(negedge clk);
    chk("flush_valid", {63'b0, out_valid}, 64'h0);
    @(negedge clk);
    chk("resume_pc", out_pc, 64'h40);
    tick(1);
    wait_done(20);

    // Misaligned redirect: sticky fault
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    tick(3);
    do_redirect(64'h42);
    chk("fault_set", {61'b0, busy, done, fault}, 64'h1);
    chk("fault_valid", {63'b0, out_valid}, 64'h0);
    pulse_start();
    do_redirect(64'h0);
    tick(3);
    chk("fault_sticky", {61'b0, busy, done, fault}, 64'h1);
    chk("fault_quiet", {63'b0, out_valid}, 64'h0);
    do_reset();
    chk("fault_cleared", {63'b0, fault}, 64'h0);

    // Redirects from DONE: back into the program, and past its end
    out_ready = 1'b1;
    pulse_start();
    wait_done(40);
    do_redirect(64'h08);
    chk("done_redirect_busy", {62'b0, busy, done}, 64'h2);
    wait_done(40);
    do_redirect(64'h50);
    chk("drain_busy", {62'b0, busy, done}, 64'h2);
    tick(1);
    chk("drain_to_done", {62'b0, busy, done}, 64'h1);

    // Asynchronous reset pulse between clock edges mid-RUN
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    tick(6);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    #1 reset_n = 1'b1;
    tick(1);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("restart_pc", out_pc, 64'h0);
    tick(1);
    wait_done(40);

    // Randomized back-pressure, redirects and stray starts
    for (int iter = 0; iter < 8; iter++) begin
      fill_mem();
      do_reset();
      out_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 150; c++) begin
        int r;
        out_ready      = ($urandom_range(0, 3) != 0);
        start          = ($urandom_range(0, 31) == 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        r = $urandom_range(0, 9);
        if (r < 7)      redirect_pc = 64'($urandom_range(0, NWORDS - 1) * 4);
        else if (r < 9) redirect_pc = 64'($urandom_range(NWORDS, NWORDS + 4) * 4);
        else            redirect_pc = 64'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(1, 3));
        tick(1);
      end
      start          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      tick(1);
      if (mstate == M_FAULT) begin
        chk("rand_fault", {61'b0, busy, done, fault}, 64'h1);
      end else begin
        wait_done(60);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 80, meaning instruction memory size in bytes (multiple of 4).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the PC and instruction-address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  meaning a pulse that begins fetching at PC 0; honoured only in IDLE.
REQ-006 SHALL have port inst_addr  output  ADDR_W  meaning the byte address driven to the combinational instruction memory, equal to the PC register.
REQ-007 SHALL have port inst_data  input  32  meaning the little-endian instruction word returned for inst_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  meaning a branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  ADDR_W  meaning the redirect target byte address.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_inst output 32, out_pc output ADDR_W, meaning the valid/ready instruction stream to decode.
REQ-011 SHALL have ports busy output 1 (state RUN or DRAIN), done output 1 (state DONE) and fault output 1 (state FAULT).

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE and FAULT.
REQ-013 IDLE->RUN SHALL occur on start; start in any other state SHALL be ignored.
REQ-014 In RUN, when pc <= MEM_BYTES-4 and the FIFO is not full, or is full with a pop in the same cycle, SHALL push {pc, inst_data} and set pc <= pc+4.
REQ-015 The FIFO SHALL hold 2 entries; out_valid = FIFO non-empty; out_inst/out_pc = head entry; pop occurs when out_valid && out_ready.
REQ-016 RUN->DRAIN SHALL occur when pc > MEM_BYTES-4; DRAIN->DONE SHALL occur when the FIFO is empty.
REQ-017 Latency: with start in cycle N, out_valid SHALL rise in cycle N+2 with out_pc=0; with out_ready held high, throughput SHALL be 1 instruction/cycle.
REQ-018 Redirect in RUN, DRAIN or DONE SHALL take priority over push: flush the FIFO, load pc <= redirect_pc, push nothing that cycle, and leave out_valid=0 the next cycle.
REQ-019 After a redirect, the state SHALL be RUN if redirect_pc <= MEM_BYTES-4, else DRAIN.
REQ-020 A redirect with redirect_pc[1:0] != 0 SHALL flush the FIFO and enter FAULT; FAULT SHALL be sticky until reset.
REQ-021 Redirect in IDLE or FAULT SHALL be ignored.
REQ-022 A pop coincident with a redirect SHALL count as consumed by decode; the flush still removes all remaining entries.
REQ-023 PC arithmetic SHALL be ADDR_W-bit unsigned; no wrap check is required beyond REQ-016.

Reset
REQ-024 Assertion of reset_n=0 SHALL, asynchronously and at any point mid-operation, force state IDLE, pc=0, FIFO count=0 and stored entries=0.
REQ-025 During and after reset, out_valid, out_inst, out_pc, busy, done and fault SHALL be 0, and inst_addr SHALL be 0.

Structure
REQ-026 Package fetch_pkg SHALL contain the state enumeration, INST_BYTES=4 and the MEM_BYTES default.
REQ-027 The 2-entry FIFO with flush SHALL be the single sub-module fetch_fifo; all other logic SHALL reside in fetch_sequencer.

Verification
REQ-028 Reset then start pulse, out_ready=1, memory word @0=32'h00800513 -> out_valid in cycle 2 after start, out_pc=0, out_inst=32'h00800513, then out_pc 4, 8, ... 76 on consecutive cycles, then done=1.
REQ-029 out_ready=0 for 5 cycles after start -> FIFO holds pc 0 and 4, inst_addr stalls at 8; releasing out_ready delivers 0, 4, 8 in order with no loss or duplication.
REQ-030 Redirect to 0x40 while the FIFO holds 2 entries and out_ready=1 -> head popped, FIFO flushed, out_valid=0 next cycle, next delivered out_pc=0x40.
REQ-031 Redirect to 0x42 -> fault=1, out_valid=0, and fault stays 1 through subsequent start and redirect until reset_n=0.
REQ-032 In DONE, redirect to 0x08 -> busy=1 and stream resumes at 0x08; redirect to 0x50 -> DRAIN then DONE with no output.
REQ-033 reset_n pulsed low mid-RUN between clock edges -> all outputs 0 immediately; a new start restarts at pc=0.
